// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared FSM state encoding and default parameters for the
//             pipeline memory stage and its SRAM controller.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // SRAM access sequencer states: one word = low half then high half
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } sram_state_t;

    // Byte address that maps onto SRAM halfword 0
    localparam logic [31:0] c_MEM_BASE_DFLT    = 32'd1024;
    // SRAM halfword address width
    localparam int          c_SRAM_AW_DFLT     = 18;
    // Extra hold cycles per halfword access
    localparam int          c_WAIT_CYCLES_DFLT = 1;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_ctrl
//  Purpose  : Splits a 32-bit load/store into two 16-bit SRAM accesses,
//             each held WAIT_CYCLES+1 cycles, and stalls the pipeline via
//             o_ready until the word is complete.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int SRAM_AW     = c_SRAM_AW_DFLT,
    parameter int WAIT_CYCLES = c_WAIT_CYCLES_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,      // memory request present this cycle
    input  logic               i_rw,         // 1 = write, 0 = read
    input  logic [SRAM_AW-1:0] i_addr,       // low-half halfword address
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ready,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic               o_sram_we_n,
    output logic [15:0]        o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [15:0]        i_sram_dq_in
);

    localparam int c_CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WAIT_CYCLES);

    sram_state_t          r_state;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_rw;
    logic [15:0]          r_wdata_hi;
    logic [31:0]          r_rdata;
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic                 r_sram_we_n;
    logic [15:0]          r_sram_dq_out;
    logic                 r_sram_dq_oe;
    logic                 w_last;

    assign w_last = (r_cnt == c_LAST);

    // Stall unless idle with nothing to do, or the word has just completed
    assign o_ready = ((r_state == S_IDLE) && !i_start) || (r_state == S_DONE);

    // Access sequencer: state, wait counter, captured read data and SRAM pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rw          <= 1'b0;
            r_wdata_hi    <= '0;
            r_rdata       <= '0;
            r_sram_addr   <= '0;
            r_sram_we_n   <= 1'b1;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_start) begin
                        // Upstream is frozen from here on, so everything the
                        // access needs is latched once and never re-sampled.
                        r_state     <= S_LOW;
                        r_rw        <= i_rw;
                        r_wdata_hi  <= i_wdata[31:16];
                        r_sram_addr <= i_addr;
                        if (i_rw) begin
                            r_sram_dq_out <= i_wdata[15:0];
                            r_sram_dq_oe  <= 1'b1;
                            r_sram_we_n   <= 1'b0;
                        end
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_state     <= S_HIGH;
                        r_sram_addr <= {r_sram_addr[SRAM_AW-1:1], 1'b1};
                        if (r_rw) begin
                            // we_n stays low; only address and data move
                            r_sram_dq_out <= r_wdata_hi;
                        end else begin
                            r_rdata[15:0] <= i_sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_state      <= S_DONE;
                        r_sram_we_n  <= 1'b1;
                        r_sram_dq_oe <= 1'b0;
                        if (!r_rw) begin
                            r_rdata[31:16] <= i_sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Pipeline advances on this edge; the held request is
                    // the one just served and must not start again.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rdata       = r_rdata;
    assign o_sram_addr   = r_sram_addr;
    assign o_sram_we_n   = r_sram_we_n;
    assign o_sram_dq_out = r_sram_dq_out;
    assign o_sram_dq_oe  = r_sram_dq_oe;

endmodule : sram_ctrl
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline memory stage. Translates the byte address into SRAM
//             halfword addresses, runs loads/stores through sram_ctrl and
//             forwards the control fields to the MEM/WB register.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = c_MEM_BASE_DFLT,
    parameter int          SRAM_AW     = c_SRAM_AW_DFLT,
    parameter int          WAIT_CYCLES = c_WAIT_CYCLES_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        val_rm,
    input  logic [3:0]         dest,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [31:0]        alu_res_out,
    output logic [3:0]         dest_out,
    output logic [31:0]        mem_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    logic               w_req;
    logic               w_rw;
    logic [SRAM_AW-1:0] w_addr_lo;

    // Read+write together is served as a write
    assign w_req = mem_r_en | mem_w_en;
    assign w_rw  = mem_w_en;

    // Word index doubled gives the low halfword; out-of-range addresses
    // simply wrap in the SRAM address space.
    assign w_addr_lo = SRAM_AW'(((alu_res - MEM_BASE) >> 2) << 1);

    // Control fields flow straight through to MEM/WB
    assign wb_en_out    = wb_en;
    assign mem_r_en_out = mem_r_en;
    assign alu_res_out  = alu_res;
    assign dest_out     = dest;

    sram_ctrl #(
        .SRAM_AW     (SRAM_AW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_sram_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_req),
        .i_rw          (w_rw),
        .i_addr        (w_addr_lo),
        .i_wdata       (val_rm),
        .o_rdata       (mem_data),
        .o_ready       (ready),
        .o_sram_addr   (sram_addr),
        .o_sram_we_n   (sram_we_n),
        .o_sram_dq_out (sram_dq_out),
        .o_sram_dq_oe  (sram_dq_oe),
        .i_sram_dq_in  (sram_dq_in)
    );

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage with a behavioural SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_AW = 18;
    localparam int c_W  = 1;

    logic              clk;
    logic              rst;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       alu_res;
    logic [31:0]       val_rm;
    logic [3:0]        dest;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic [31:0]       alu_res_out;
    logic [3:0]        dest_out;
    logic [31:0]       mem_data;
    logic              ready;
    logic [c_AW-1:0]   sram_addr;
    logic              sram_we_n;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sram_mem [0:63];

    mem_stage #(
        .MEM_BASE    (32'd1024),
        .SRAM_AW     (c_AW),
        .WAIT_CYCLES (c_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .alu_res      (alu_res),
        .val_rm       (val_rm),
        .dest         (dest),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .dest_out     (dest_out),
        .mem_data     (mem_data),
        .ready        (ready),
        .sram_addr    (sram_addr),
        .sram_we_n    (sram_we_n),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_oe   (sram_dq_oe),
        .sram_dq_in   (sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small asynchronous-read SRAM covering the low 64 halfwords
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] ds);
        mem_r_en = r;
        mem_w_en = w;
        alu_res  = a;
        val_rm   = d;
        dest     = ds;
        wb_en    = r;
    endtask

    // One full access with the pipeline advancing on ready; checks every cycle.
    task automatic access(input string nm, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [c_AW-1:0] exp_lo, input logic [31:0] exp_rd);
        logic is_wr;
        is_wr = w;
        drive(r, w, a, d, 4'd5);
        #2;
        chk({nm, " c0 ready"}, 32'(ready), 32'd0);
        chk({nm, " c0 we_n"},  32'(sram_we_n), 32'd1);
        tick();
        for (int k = 1; k <= 2 * c_W + 2; k++) begin
            #2;
            chk({nm, " ready"}, 32'(ready), 32'd0);
            chk({nm, " addr"},  32'(sram_addr), (k <= c_W + 1) ? 32'(exp_lo) : 32'(exp_lo | 1'b1));
            chk({nm, " we_n"},  32'(sram_we_n), is_wr ? 32'd0 : 32'd1);
            chk({nm, " oe"},    32'(sram_dq_oe), 32'(is_wr));
            if (is_wr)
                chk({nm, " dq"}, 32'(sram_dq_out), (k <= c_W + 1) ? 32'(d[15:0]) : 32'(d[31:16]));
            tick();
        end
        #2;
        chk({nm, " done ready"}, 32'(ready), 32'd1);
        chk({nm, " done we_n"},  32'(sram_we_n), 32'd1);
        chk({nm, " done oe"},    32'(sram_dq_oe), 32'd0);
        if (!is_wr) chk({nm, " rdata"}, mem_data, exp_rd);
        tick();
    endtask

    typedef struct {
        logic        wb;
        logic [3:0]  ds;
        logic [31:0] alu;
        logic        exp_wb;
        logic [3:0]  exp_ds;
        logic [31:0] exp_alu;
    } pt_vec_t;

    pt_vec_t vecs [4];

    initial begin
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
        vecs[0] = '{1'b1, 4'd3,  32'd7,          1'b1, 4'd3,  32'd7};
        vecs[1] = '{1'b0, 4'd15, 32'hFFFF_FFFF,  1'b0, 4'd15, 32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 4'd0,  32'd1024,       1'b1, 4'd0,  32'd1024};
        vecs[3] = '{1'b1, 4'd9,  32'h8000_0001,  1'b1, 4'd9,  32'h8000_0001};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        // Reset state
        chk("rst ready",    32'(ready), 32'd1);
        chk("rst we_n",     32'(sram_we_n), 32'd1);
        chk("rst oe",       32'(sram_dq_oe), 32'd0);
        chk("rst addr",     32'(sram_addr), 32'd0);
        chk("rst dq_out",   32'(sram_dq_out), 32'd0);
        chk("rst mem_data", mem_data, 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: reset lands while the high half of a store is in progress
        drive(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 4'd1);
        tick();
        tick();
        tick();
        #1;
        chk("t1 in HIGH addr", 32'(sram_addr), 32'd1);
        chk("t1 in HIGH we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk("t1 async we_n",  32'(sram_we_n), 32'd1);
        chk("t1 async oe",    32'(sram_dq_oe), 32'd0);
        chk("t1 async ready", 32'(ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("t1 idle ready", 32'(ready), 32'd1);
        chk("t1 idle we_n",  32'(sram_we_n), 32'd1);
        chk("t1 idle addr",  32'(sram_addr), 32'd0);
        #1;

        // Test 2: store 0xDEADBEEF at the base address
        access("t2 st", 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 18'd0, 32'd0);
        // Test 3: load it back
        access("t3 ld", 1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hDEAD_BEEF);

        // Test 4: non-memory instructions pass straight through
        for (int i = 0; i < 4; i++) begin
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
            wb_en    = vecs[i].wb;
            dest     = vecs[i].ds;
            alu_res  = vecs[i].alu;
            val_rm   = 32'h5555_AAAA;
            #2;
            chk("t4 wb_en_out",   32'(wb_en_out), 32'(vecs[i].exp_wb));
            chk("t4 dest_out",    32'(dest_out), 32'(vecs[i].exp_ds));
            chk("t4 alu_res_out", alu_res_out, vecs[i].exp_alu);
            chk("t4 mem_r_en_out", 32'(mem_r_en_out), 32'd0);
            chk("t4 ready",       32'(ready), 32'd1);
            chk("t4 we_n",        32'(sram_we_n), 32'd1);
            chk("t4 oe",          32'(sram_dq_oe), 32'd0);
            chk("t4 mem_data",    mem_data, 32'hDEAD_BEEF);
            tick();
        end

        // Test 5: seed two words, then back-to-back loads (addr 2,3,4,5)
        access("t5 st0", 1'b0, 1'b1, 32'd1028, 32'hA5A5_1111, 18'd2, 32'd0);
        access("t5 st1", 1'b0, 1'b1, 32'd1032, 32'h0F0F_2222, 18'd4, 32'd0);
        access("t5 ld0", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hA5A5_1111);
        access("t5 ld1", 1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 32'h0F0F_2222);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2;
        chk("t5 after ready", 32'(ready), 32'd1);
        chk("t5 after addr",  32'(sram_addr), 32'd5);
        tick();

        // Test 6: read+write together is a write; address wraps to halfword 2
        access("t6 rw", 1'b1, 1'b1, 32'd1024 + 32'd524288 + 32'd4, 32'hCAFE_F00D, 18'd2, 32'd0);
        access("t6 ld", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
